// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write, two-read register file with a clear sweep FSM
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [ADDR_W:0]   NREGS = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              busy_next;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              ok0, ok1;

    // A write qualifies only in IDLE, in range, and not aimed at a hardwired zero register.
    assign ok0 = we0 && ({1'b0, waddr0} < NREGS) && !(ZERO_REG && (waddr0 == '0))
                 && (state == IDLE) && !rst;
    assign ok1 = we1 && ({1'b0, waddr1} < NREGS) && !(ZERO_REG && (waddr1 == '0))
                 && (state == IDLE) && !rst;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
        busy_next = (state_next == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            clr_busy <= busy_next;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == i[ADDR_W-1:0]) regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ok0 && (waddr0 == i[ADDR_W-1:0])) regs[i] <= wdata0;
                if (ok1 && (waddr1 == i[ADDR_W-1:0])) regs[i] <= wdata1;
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_a == i[ADDR_W-1:0]) rdata_a = regs[i];
        end
        if (ok0 && (waddr0 == raddr_a)) rdata_a = wdata0;
        if (ok1 && (waddr1 == raddr_a)) rdata_a = wdata1;
        if (rst || clr_busy) rdata_a = '0;
    end

    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_b == i[ADDR_W-1:0]) rdata_b = regs[i];
        end
        if (ok0 && (waddr0 == raddr_b)) rdata_b = wdata0;
        if (ok1 && (waddr1 == raddr_b)) rdata_b = wdata1;
        if (rst || clr_busy) rdata_b = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with NUM_REGS=24
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1;
    logic [AW-1:0] waddr0, waddr1, raddr_a, raddr_b;
    logic [DW-1:0] wdata0, wdata1, rdata_a, rdata_b;
    logic          clr_req, clr_busy;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        int            port;
        logic [DW-1:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Port selector: 0 = rdata_a, 1 = rdata_b, 2 = clr_busy.
    task automatic expect_out(input string name, input int port, input logic [DW-1:0] exp);
        chk_t c;
        c.name = name;
        c.port = port;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [DW-1:0] act;
            c = sb.pop_front();
            case (c.port)
                0:       act = rdata_a;
                1:       act = rdata_b;
                default: act = {{(DW-1){1'b0}}, clr_busy};
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fails++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
        clr_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        raddr_a = '0; raddr_b = '0;

        // Held in reset: write attempt ignored, reads forced to zero.
        step();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; raddr_a = 5'd5;
        expect_out("rst_read_a", 0, 32'h0);
        expect_out("rst_busy", 2, 32'h0);
        step();
        rst = 1'b0;
        idle_inputs();
        expect_out("post_rst_r5", 0, 32'h0);
        step();

        // Port 0 write with same-cycle bypass, then stored read.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; raddr_a = 5'd5;
        expect_out("bypass_a_r5", 0, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        expect_out("stored_r5", 0, 32'hDEAD_BEEF);
        step();

        // Both ports hit r7: port 1 wins, bypass on B shows port 1 data.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr_b = 5'd7;
        expect_out("collide_bypass_b", 1, 32'h22);
        step();
        idle_inputs();
        raddr_a = 5'd7;
        expect_out("collide_r7", 0, 32'h22);
        step();

        // Writes to r0 and to out-of-range address are dropped, no bypass.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
        we1 = 1'b1; waddr1 = 5'd24; wdata1 = 32'hCAFE;
        raddr_a = 5'd0; raddr_b = 5'd24;
        expect_out("r0_no_bypass", 0, 32'h0);
        expect_out("oor_no_bypass", 1, 32'h0);
        step();
        idle_inputs();
        expect_out("r0_after", 0, 32'h0);
        expect_out("oor_read_b", 1, 32'h0);
        step();
        raddr_a = 5'd5; raddr_b = 5'd7;
        expect_out("r5_unchanged", 0, 32'hDEAD_BEEF);
        expect_out("r7_unchanged", 1, 32'h22);
        step();

        // Fill r1..r23 with 0x1000_0000+i.
        for (int i = 1; i < NR; i++) begin
            we0 = 1'b1; waddr0 = AW'(i); wdata0 = 32'h1000_0000 + i;
            step();
        end
        idle_inputs();
        raddr_a = 5'd1; raddr_b = 5'd23;
        expect_out("fill_r1", 0, 32'h1000_0001);
        expect_out("fill_r23", 1, 32'h1000_0017);
        step();

        // Write and clr_req together: write commits (visible via bypass), sweep overwrites.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAAAA; clr_req = 1'b1; raddr_a = 5'd3;
        expect_out("clr_cycle_bypass", 0, 32'hAAAA);
        expect_out("clr_cycle_busy", 2, 32'h0);
        step();
        clr_req = 1'b0;
        for (int i = 0; i < NR; i++) begin
            we0 = 1'b1; waddr0 = AW'((i % (NR - 1)) + 1); wdata0 = 32'h5555_0000 + i;
            raddr_a = 5'd5; raddr_b = waddr0;
            clr_req = (i == NR - 1);
            expect_out($sformatf("sweep_busy_%0d", i), 2, 32'h1);
            expect_out($sformatf("sweep_rd_a_%0d", i), 0, 32'h0);
            expect_out($sformatf("sweep_rd_b_%0d", i), 1, 32'h0);
            step();
        end
        idle_inputs();
        expect_out("sweep_done_busy", 2, 32'h0);
        for (int i = 0; i < NR; i++) begin
            raddr_a = AW'(i); raddr_b = AW'(NR - 1 - i);
            expect_out($sformatf("cleared_a_%0d", i), 0, 32'h0);
            expect_out($sformatf("cleared_b_%0d", i), 1, 32'h0);
            step();
        end
        expect_out("no_retrigger_busy", 2, 32'h0);
        step();

        // Reset mid-sweep at idx=10 aborts the sweep and clears everything.
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h2020_2020;
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h1010_1010;
        step();
        idle_inputs();
        raddr_a = 5'd20; raddr_b = 5'd10;
        expect_out("pre_abort_r20", 0, 32'h2020_2020);
        expect_out("pre_abort_r10", 1, 32'h1010_1010);
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #1;
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0BAD;
        expect_out("abort_busy_now", 2, 32'h0);
        expect_out("abort_rd_a", 0, 32'h0);
        step();
        rst = 1'b0;
        idle_inputs();
        raddr_a = 5'd20; raddr_b = 5'd12;
        expect_out("abort_r20", 0, 32'h0);
        expect_out("abort_r12", 1, 32'h0);
        expect_out("abort_idle_busy", 2, 32'h0);
        step();
        raddr_a = 5'd5; raddr_b = 5'd24;
        expect_out("abort_r5", 0, 32'h0);
        expect_out("oor_b_24", 1, 32'h0);
        step();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
